// File: rtl/exu_div_pkg.sv
// Shared widths, handshake levels, op bit positions and FSM encoding for the
// execute-unit radix-2 divider.
package exu_div_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // Start line levels as driven by the mul/div controller.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // Bit positions inside the one-hot op vector {remu, rem, divu, div}.
  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_END  = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [REG_DATA_WIDTH-1:0] sign_fix(
    input logic [REG_DATA_WIDTH-1:0] v,
    input logic                      neg
  );
    return neg ? (~v + {{(REG_DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/exu_div.sv
// RV32M DIV/DIVU/REM/REMU: restoring radix-2 divider, one quotient bit per
// cycle, with divide-by-zero and signed-overflow results resolved on accept.
module exu_div
  import exu_div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [REG_DATA_WIDTH-1:0] dividend_i,
  input  logic [REG_DATA_WIDTH-1:0] divisor_i,
  input  logic [3:0]                op_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  output logic [REG_DATA_WIDTH-1:0] result_o,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);

  localparam int W = REG_DATA_WIDTH;

  div_state_e              state_q, state_d;
  logic                    signed_q, signed_d;
  logic                    is_rem_q, is_rem_d;
  logic                    neg_quot_q, neg_quot_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [W-1:0]            quot_q, quot_d;
  logic [W-1:0]            rem_q, rem_d;
  logic [W-1:0]            dvs_q, dvs_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [W-1:0]            result_q, result_d;

  // Accept-time decode of the incoming operands.
  logic         accept;
  logic         in_signed, in_is_rem;
  logic         dvd_neg, dvs_neg;
  logic [W-1:0] dvd_mag, dvs_mag;
  logic         div_by_zero, overflow;

  // One restoring step on the latched state.
  logic [W:0]   shifted, diff;
  logic [W-1:0] step_rem, step_quot;
  logic [W-1:0] final_val;

  always_comb begin
    accept      = (start_i == DivStart) &&
                  (op_i[OP_DIV] | op_i[OP_DIVU] | op_i[OP_REM] | op_i[OP_REMU]);
    in_signed   = op_i[OP_DIV] | op_i[OP_REM];
    in_is_rem   = op_i[OP_REM] | op_i[OP_REMU];
    dvd_neg     = in_signed & dividend_i[W-1];
    dvs_neg     = in_signed & divisor_i[W-1];
    dvd_mag     = sign_fix(dividend_i, dvd_neg);
    dvs_mag     = sign_fix(divisor_i, dvs_neg);
    div_by_zero = (divisor_i == '0);
    overflow    = in_signed && (dividend_i == {1'b1, {(W-1){1'b0}}}) &&
                  (divisor_i == '1);

    // Bit W of the 33-bit difference is the borrow: set means restore.
    shifted = {rem_q, quot_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[W]) begin
      step_rem  = diff[W-1:0];
      step_quot = {quot_q[W-2:0], 1'b1};
    end else begin
      step_rem  = shifted[W-1:0];
      step_quot = {quot_q[W-2:0], 1'b0};
    end
    final_val = is_rem_q ? sign_fix(step_rem, signed_q & neg_rem_q)
                         : sign_fix(step_quot, signed_q & neg_quot_q);
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    signed_d    = signed_q;
    is_rem_d    = is_rem_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    reg_waddr_d = reg_waddr_q;
    result_d    = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          signed_d   = in_signed;
          is_rem_d   = in_is_rem;
          neg_quot_d = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          quot_d     = dvd_mag;
          dvs_d      = dvs_mag;
          rem_d      = '0;
          cnt_d      = '0;
          waddr_d    = reg_waddr_i;
          if (div_by_zero) begin
            result_d    = in_is_rem ? dividend_i : '1;
            reg_waddr_d = reg_waddr_i;
            state_d     = S_END;
          end else if (overflow) begin
            result_d    = in_is_rem ? '0 : {1'b1, {(W-1){1'b0}}};
            reg_waddr_d = reg_waddr_i;
            state_d     = S_END;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Controller dropping start mid-operation abandons it silently.
        if (start_i == DivStop) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d    = final_val;
            reg_waddr_d = waddr_q;
            state_d     = S_END;
          end
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      signed_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      reg_waddr_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      signed_q    <= signed_d;
      is_rem_q    <= is_rem_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      reg_waddr_q <= reg_waddr_d;
      result_q    <= result_d;
    end
  end

  assign result_o    = result_q;
  assign reg_waddr_o = reg_waddr_q;
  assign busy_o      = (state_q == S_CALC);
  assign ready_o     = (state_q == S_END);

endmodule

// File: tb/tb_exu_div.sv
// Scoreboard bench for exu_div: directed ops push expected result, address and
// ready cycle; a negedge monitor pops and compares on every ready pulse.
module tb_exu_div;
  import exu_div_pkg::*;

  localparam logic [3:0] OP_DIV_V  = 4'b0001;
  localparam logic [3:0] OP_DIVU_V = 4'b0010;
  localparam logic [3:0] OP_REM_V  = 4'b0100;
  localparam logic [3:0] OP_REMU_V = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [3:0]  op_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  exu_div dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .op_i        (op_i),
    .reg_waddr_i (reg_waddr_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  waddr;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = '0;
  logic [4:0]  last_waddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result_o, mon_e.res);
        check("waddr", 32'(reg_waddr_o), 32'(mon_e.waddr));
        check("ready_cycle", 32'(cyc), 32'(mon_e.at));
        check("busy_with_ready", 32'(busy_o), 32'd0);
      end
    end
  end

  // Issue one op, hold start until ready (bounded), scrambling operand inputs
  // after accept since only the latched copies may be used.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp, input bit special);
    int t0;
    int busy_cnt;
    bit got;
    exp_t e;
    @(negedge clk);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    t0          = cyc;
    e.res       = exp;
    e.waddr     = wa;
    e.at        = t0 + (special ? 1 : 33);
    sb.push_back(e);
    busy_cnt = 0;
    got      = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      dividend_i  = $urandom();
      divisor_i   = $urandom();
      reg_waddr_i = 5'($urandom());
      if (busy_o) busy_cnt++;
      if (ready_o) got = 1'b1;
    end
    start_i = 1'b0;
    op_i    = '0;
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    check("busy_cycles", 32'(busy_cnt), special ? 32'd0 : 32'd32);
    last_result = exp;
    last_waddr  = wa;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_waddr", 32'(reg_waddr_o), 32'd0);
    rst = 1'b0;

    // start with no op selected is ignored
    @(negedge clk);
    start_i = 1'b1; op_i = '0; dividend_i = 32'd1; divisor_i = 32'd1;
    repeat (3) begin
      @(negedge clk);
      check("noop_busy", 32'(busy_o), 32'd0);
    end
    start_i = 1'b0;

    do_op(OP_DIVU_V, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
    do_op(OP_REMU_V, 32'd100, 32'd7, 5'd6, 32'd2, 1'b0);
    do_op(OP_DIV_V, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b0);
    do_op(OP_REM_V, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b0);
    do_op(OP_DIV_V, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 1'b0);
    do_op(OP_REM_V, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 1'b0);
    do_op(OP_DIV_V, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b1);
    do_op(OP_REMU_V, 32'd5, 32'd0, 5'd13, 32'd5, 1'b1);
    do_op(OP_REM_V, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFB, 1'b1);
    do_op(OP_DIV_V, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
    do_op(OP_REM_V, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1'b1);
    do_op(OP_DIVU_V, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1'b0);
    do_op(OP_DIV_V, 32'h8000_0000, 32'd1, 5'd18, 32'h8000_0000, 1'b0);
    do_op(OP_REMU_V, 32'hFFFF_FFFF, 32'd10, 5'd19, 32'd5, 1'b0);
    do_op(OP_DIVU_V, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd1, 1'b0);

    // abort mid-CALC, then re-accept
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU_V; dividend_i = 32'd1000; divisor_i = 32'd3;
    reg_waddr_i = 5'd7;
    t0 = cyc;
    repeat (10) @(negedge clk);
    start_i = 1'b0; op_i = '0;
    @(negedge clk);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_result", result_o, last_result);
    check("abort_waddr", 32'(reg_waddr_o), 32'(last_waddr));
    check("abort_cycle", 32'(cyc), 32'(t0 + 11));
    do_op(OP_DIVU_V, 32'd9, 32'd3, 5'd8, 32'd3, 1'b0);

    // async reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU_V; dividend_i = 32'd50; divisor_i = 32'd5;
    reg_waddr_i = 5'd9;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0; op_i = '0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // back-to-back: second accept lands in the IDLE cycle right after END
    do_op(OP_DIVU_V, 32'd1000, 32'd10, 5'd10, 32'd100, 1'b0);
    do_op(OP_DIVU_V, 32'hFFFF_FFFF, 32'd16, 5'd11, 32'h0FFF_FFFF, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
